sync_fifo_prog: RTL and testbench

SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

---
 rtl/sync_fifo_pkg.sv | 18 +
 rtl/sync_fifo_mem.sv | 30 +++
 rtl/sync_fifo_prog.sv | 102 ++++++++++
 tb/tb_sync_fifo_prog.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and width helpers for the programmable-threshold synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_AE_THRESH = 1;

  // Pointer width; DEPTH is a power of two >= 2 so this is at least 1.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Count needs one extra bit to represent the full value DEPTH.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one write port and one registered read port with async-cleared output.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_wr_en,
  input  logic [ptr_w(DEPTH)-1:0]   i_wr_addr,
  input  logic [WIDTH-1:0]          i_wr_data,
  input  logic                      i_rd_en,
  input  logic [ptr_w(DEPTH)-1:0]   i_rd_addr,
  output logic [WIDTH-1:0]          o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // A same-address read and write (full FIFO, both accepted) returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          o_rd_data <= '0;
    else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty levels.
// Optional sticky overflow/underflow flags are enabled by defining SYNC_FIFO_ERR_EN.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr,
  input  logic                      rd,
  input  logic [WIDTH-1:0]          Wdata,
  input  logic                      err_clr,
  output logic [WIDTH-1:0]          Rdata,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_wr_en;
  logic          w_rd_en;

  // Handshake: wr/rd are requests sampled on the rising edge; a request takes effect
  // only when accepted. A write into a full FIFO is accepted only alongside a read.
  assign w_wr_en = wr && (!full || rd);
  assign w_rd_en = rd && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst       (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (Wdata),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (Rdata)
  );

  // Status flags decode from the registered count only.
  assign count        = r_count;
  assign full         = (r_count == CW'(DEPTH));
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= CW'(AF_THRESH));
  assign almost_empty = (r_count <= CW'(AE_THRESH));

`ifdef SYNC_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // A new error in the same cycle as err_clr wins, so the event is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (r_overflow  && !err_clr) || (wr && !w_wr_en);
      r_underflow <= (r_underflow && !err_clr) || (rd && empty);
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: directed scenarios plus random traffic vs a queue model.
module tb_sync_fifo_prog;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;
  localparam int CW    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             wr, rd, err_clr;
  logic [WIDTH-1:0] Wdata;
  logic [WIDTH-1:0] Rdata;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0]    count;

  sync_fifo_prog #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .rd           (rd),
    .Wdata        (Wdata),
    .err_clr      (err_clr),
    .Rdata        (Rdata),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_rdata;
  logic             exp_ovf;
  logic             exp_udf;
  int               n_checks;
  int               n_pass;
  int               n_pushed;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Behaviour of one rising edge, from the pre-edge occupancy and the sampled requests.
  task automatic model_step(input logic w, input logic r, input logic [WIDTH-1:0] d,
                            input logic ec);
    int  occ;
    logic wa, ra;
    occ = exp_q.size();
    wa  = w && ((occ < DEPTH) || r);
    ra  = r && (occ > 0);
    if (ra) exp_rdata = exp_q.pop_front();
    if (wa) begin
      exp_q.push_back(d);
      n_pushed++;
    end
`ifdef SYNC_FIFO_ERR_EN
    exp_ovf = (exp_ovf && !ec) || (w && !wa);
    exp_udf = (exp_udf && !ec) || (r && (occ == 0));
`else
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
`endif
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_rdata = '0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    int occ;
    occ = exp_q.size();
    check_eq({tag, ".rdata"}, 32'(Rdata), 32'(exp_rdata));
    check_eq({tag, ".count"}, 32'(count), 32'(occ));
    check_eq({tag, ".full"},  32'(full),  32'(occ == DEPTH));
    check_eq({tag, ".empty"}, 32'(empty), 32'(occ == 0));
    check_eq({tag, ".afull"}, 32'(almost_full),  32'(occ >= AF));
    check_eq({tag, ".aempty"}, 32'(almost_empty), 32'(occ <= AE));
    check_eq({tag, ".ovf"},   32'(overflow),  32'(exp_ovf));
    check_eq({tag, ".udf"},   32'(underflow), 32'(exp_udf));
  endtask

  // ---------------- driver tasks (called just after a falling edge) ----------------
  task automatic cycle(input string tag, input logic w, input logic r,
                       input logic [WIDTH-1:0] d, input logic ec);
    wr = w; rd = r; Wdata = d; err_clr = ec;
    @(posedge clk);
    model_step(w, r, d, ec);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic async_reset(input string tag);
    wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
    reset = 1'b1;
    #1;
    check_eq({tag, ".async_empty"}, 32'(empty), 32'd1);
    check_eq({tag, ".async_count"}, 32'(count), 32'd0);
    check_eq({tag, ".async_rdata"}, 32'(Rdata), 32'd0);
    model_reset();
    @(negedge clk);
    check_outputs({tag, ".held"});
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start_pushed;
    int iter;
    int p_wr;
    int p_rd;
    n_checks = 0; n_pass = 0; n_pushed = 0;
    reset = 1'b1; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; Wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    reset = 1'b0;

    // Fill 0x00..0x07, watching almost_full at 6 and full at 8, then drain in order.
    for (int i = 0; i < DEPTH; i++) cycle($sformatf("fill%0d", i), 1'b1, 1'b0, WIDTH'(i), 1'b0);
    check_eq("fill.full", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) cycle($sformatf("drain%0d", i), 1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("drain.last", 32'(Rdata), 32'h07);
    check_eq("drain.empty", 32'(empty), 32'd1);

    // Reset in the middle of a burst, then confirm stale words are gone.
    for (int i = 0; i < 5; i++) cycle("burst", 1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
    async_reset("midrst");
    cycle("post_rst_wr", 1'b1, 1'b0, 8'hA5, 1'b0);
    cycle("post_rst_rd", 1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("post_rst.rdata", 32'(Rdata), 32'hA5);

    // Full with simultaneous read and write.
    for (int i = 0; i < DEPTH; i++) cycle("fill2", 1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
    cycle("full_wrrd", 1'b1, 1'b1, 8'h55, 1'b0);
    check_eq("full_wrrd.count", 32'(count), 32'd8);
    for (int i = 0; i < DEPTH; i++) cycle("drain2", 1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("full_wrrd.last", 32'(Rdata), 32'h55);

    // Empty with simultaneous read and write: only the write lands.
    cycle("empty_wrrd", 1'b1, 1'b1, 8'h3C, 1'b0);
    check_eq("empty_wrrd.rdata", 32'(Rdata), 32'h55);
    cycle("empty_wrrd_rd", 1'b0, 1'b1, 8'h00, 1'b0);

    // Error flags: overflow, underflow, clear, and clear colliding with a new error.
    for (int i = 0; i < DEPTH; i++) cycle("fill3", 1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
    cycle("ovf", 1'b1, 1'b0, 8'hEE, 1'b0);
    cycle("ovf_hold", 1'b0, 1'b0, 8'h00, 1'b0);
    cycle("ovf_clr_collide", 1'b1, 1'b0, 8'hEE, 1'b1);
    cycle("ovf_clr", 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle("drain3", 1'b0, 1'b1, 8'h00, 1'b0);
    cycle("udf", 1'b0, 1'b1, 8'h00, 1'b0);
    cycle("udf_hold", 1'b0, 1'b0, 8'h00, 1'b0);
    cycle("udf_clr", 1'b0, 1'b0, 8'h00, 1'b1);

    // Random traffic for at least 20 pointer wraps.
    start_pushed = n_pushed;
    iter = 0;
    p_wr = 50;
    p_rd = 50;
    while ((n_pushed - start_pushed) < 20 * DEPTH && iter < 5000) begin
      if (iter % 40 == 0) begin
        p_wr = $urandom_range(25, 85);
        p_rd = $urandom_range(25, 85);
      end
      cycle("rand",
            1'($urandom_range(0, 99) < p_wr),
            1'($urandom_range(0, 99) < p_rd),
            8'($urandom_range(0, 255)),
            1'($urandom_range(0, 19) == 0));
      iter++;
    end
    check_eq("rand.wrap_budget", 32'((n_pushed - start_pushed) >= 20 * DEPTH), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
